// File: rtl/i2c_eeprom_seq.sv
// i2c_eeprom_seq: command sequencer driving an I2C EEPROM byte engine with write-cycle wait, verify and timeout
module i2c_eeprom_seq #(
  parameter int ADDR_W         = 11,
  parameter int TWR_CYCLES     = 5000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic              cmd_verify,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_data,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_timeout,
  output logic              rsp_mismatch,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_w,
  input  logic [7:0]        data_r,
  input  logic              ack
);
  typedef enum logic [2:0] {IDLE, WRITE, TWR, READ, RESP} state_t;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TWR_LAST = CNT_W'(TWR_CYCLES - 1);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             vfy;
  // saturating increment of the shared wait/timeout counter
  assign cnt_nx = &cnt ? cnt : cnt + 1'b1;
  // sequencer FSM with all outputs registered; strobes drop on the ack edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      vfy          <= 1'b0;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      rsp_mismatch <= 1'b0;
      wr           <= 1'b0;
      rd           <= 1'b0;
      addr         <= '0;
      data_w       <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          addr         <= cmd_addr;
          data_w       <= cmd_data;
          vfy          <= cmd_verify & ~cmd_op;
          cnt          <= '0;
          cmd_ready    <= 1'b0;
          rsp_data     <= '0;
          rsp_timeout  <= 1'b0;
          rsp_mismatch <= 1'b0;
          wr           <= ~cmd_op;
          rd           <= cmd_op;
          state        <= cmd_op ? READ : WRITE;
        end
        WRITE, READ: if (ack) begin
          wr  <= 1'b0;
          rd  <= 1'b0;
          cnt <= '0;
          if (state == WRITE) state <= TWR;
          else begin
            rsp_data     <= data_r;
            rsp_mismatch <= vfy && (data_r != data_w);
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end else if (cnt == TO_LAST) begin
          wr          <= 1'b0;
          rd          <= 1'b0;
          rsp_timeout <= 1'b1;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end else cnt <= cnt_nx;
        TWR: if (cnt == TWR_LAST) begin
          cnt <= '0;
          if (vfy) begin
            rd    <= 1'b1;
            state <= READ;
          end else begin
            rsp_data  <= data_w;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end else cnt <= cnt_nx;
        RESP: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
